ps2_rx: RTL
===========

PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer flops on ps2_clk and ps2_data (minimum 2).
REQ-002 SHALL have parameter FILTER_LEN, default 4: consecutive agreeing synchronized samples required to change the filtered ps2_clk level.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50000: clk cycles without a falling edge mid-frame before abort (used only with PS2_TIMEOUT_EN).
REQ-004 SHALL have port clk, input, 1: system clock; all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port ps2_clk, input, 1: raw PS/2 clock line, asynchronous to clk.
REQ-007 SHALL have port ps2_data, input, 1: raw PS/2 data line, asynchronous to clk.
REQ-008 SHALL have port code, output, 8: last correctly received scan code; feeds the scan-code buffer/decoder stage.
REQ-009 SHALL have port code_valid, output, 1: one-cycle pulse; code is new.
REQ-010 SHALL have port parity_err, output, 1: one-cycle pulse; frame dropped on odd-parity failure.
REQ-011 SHALL have port frame_err, output, 1: one-cycle pulse; frame dropped on bad stop bit or timeout.
REQ-012 SHALL have port busy, output, 1: high while state is not IDLE.

Function
REQ-013 SHALL pass ps2_clk and ps2_data each through SYNC_STAGES flops before any use.
REQ-014 SHALL keep a filtered clock level that changes only after FILTER_LEN consecutive synchronized samples differ from it; shorter glitches SHALL be ignored.
REQ-015 SHALL generate fall_evt for exactly one cycle when the filtered level goes 1->0; the synchronized ps2_data value in that cycle is the sampled bit.
REQ-016 SHALL implement states IDLE, DATA, PARITY, STOP; no state change except on fall_evt, reset, or timeout.
REQ-017 IDLE: on fall_evt with sampled bit 0 (start) go to DATA, bit counter 0; sampled bit 1 SHALL be ignored, stay IDLE.
REQ-018 DATA: on each fall_evt shift sampled bit in LSB-first; after the 8th bit go to PARITY.
REQ-019 PARITY: on fall_evt capture parity bit; go to STOP.
REQ-020 STOP: on fall_evt return to IDLE and evaluate: odd parity (XOR of 8 data bits and parity bit equals 1) and stop bit 1.
REQ-021 Both checks pass: code updated and code_valid high in the cycle after the STOP fall_evt cycle.
REQ-022 Parity fails: parity_err pulse instead, code unchanged; parity failure SHALL take priority, so parity_err alone when both fail.
REQ-023 Parity passes, stop bit 0: frame_err pulse, code unchanged.
REQ-024 code SHALL hold its value between pulses; at most one of code_valid/parity_err/frame_err SHALL be high in any cycle.
REQ-025 Back-to-back frames SHALL be received with no required idle gap beyond the PS/2 stop-bit time.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, synchronizer and filtered level 1, counters 0, code 0x00, code_valid/parity_err/frame_err/busy 0.
REQ-027 Reset mid-frame SHALL discard the partial frame; after release the next start bit begins a new frame with no error pulse.

Configuration
REQ-028 Macro PS2_TIMEOUT_EN defined: a counter SHALL clear on every fall_evt and in IDLE; reaching TIMEOUT_CYCLES outside IDLE SHALL return to IDLE with a one-cycle frame_err pulse.
REQ-029 PS2_TIMEOUT_EN undefined: no timeout counter SHALL exist; a partial frame waits indefinitely for further falling edges.

Verification
REQ-030 Frame start 0, data 0x1C LSB-first, parity 0, stop 1 -> one code_valid pulse, code=0x1C, busy low after.
REQ-031 Data 0x1C with parity 1 -> one parity_err pulse, no code_valid, code keeps prior value.
REQ-032 Data 0xF0, parity 1, stop 0 -> one frame_err pulse, no code_valid.
REQ-033 FILTER_LEN=4, 2-cycle low glitch on ps2_clk in IDLE with ps2_data=0 -> no state change, busy stays 0.
REQ-034 PS2_TIMEOUT_EN, TIMEOUT_CYCLES=100: 5 bits then idle 100 cycles -> frame_err pulse, IDLE; next frame 0xF0 (parity 1) -> code=0xF0.
REQ-035 rst_n low after 4 data bits, release, send 0x1C frame -> no error pulse, code=0x1C.

Source files
------------

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes and deglitches the PS/2 lines, frames 11-bit words.
// Optional mid-frame watchdog enabled with the PS2_TIMEOUT_EN macro.
module ps2_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int FW = $clog2(FILTER_LEN + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  if (SYNC_STAGES < 2 || FILTER_LEN < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("ps2_rx: SYNC_STAGES>=2, FILTER_LEN>=1, TIMEOUT_CYCLES>=1 required");
  end

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_s, data_s;
  logic                   filt_lvl, filt_prev;
  logic [FW-1:0]          filt_cnt;
  logic                   fall_evt;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic [7:0] code_d;
  logic       cv_d, pe_d, fe_d;

  // Stage 0: synchronizers, idle-high after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  // Stage 1: level filter; a run shorter than FILTER_LEN never reaches the flip
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_lvl  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      filt_prev <= filt_lvl;
      if (clk_s != filt_lvl) begin
        if (filt_cnt == FW'(FILTER_LEN - 1)) begin
          filt_lvl <= clk_s;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign fall_evt = filt_prev & ~filt_lvl;

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic          to_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            to_cnt <= '0;
    else if (state_q == IDLE || fall_evt)  to_cnt <= '0;
    else                                   to_cnt <= to_cnt + 1'b1;
  end

  assign to_hit = (state_q != IDLE) && !fall_evt && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`endif

  // Stage 2: frame FSM; verdict registered so pulses land the cycle after the stop edge
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    code_d    = code;
    cv_d      = 1'b0;
    pe_d      = 1'b0;
    fe_d      = 1'b0;
    if (fall_evt) begin
      case (state_q)
        IDLE: if (!data_s) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end
        DATA: begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = data_s;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!(^{shift_q, par_q})) pe_d = 1'b1;
          else if (!data_s)         fe_d = 1'b1;
          else begin
            code_d = shift_q;
            cv_d   = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
`ifdef PS2_TIMEOUT_EN
    if (to_hit) begin
      state_d = IDLE;
      fe_d    = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      code       <= 8'h00;
      code_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      code       <= code_d;
      code_valid <= cv_d;
      parity_err <= pe_d;
      frame_err  <= fe_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule
